// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian words from a byte stream and writes them
// into instruction memory while holding the CPU stalled.
`timescale 1ns/1ps
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   load_words,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          imem_we,
    output logic [31:0]   imem_wa,
    output logic [31:0]   imem_wd,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic [31:0]   checksum
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t        state, state_nx;
    logic [AW:0]   n_words;
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic          last_word;

    assign last_word = ({1'b0, word_idx} == (n_words - ONE_W));
    assign imem_wa   = {{(30-AW){1'b0}}, word_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Handshake and status outputs decode the registered state only.
    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (load_words == '0) ? DONE : RECV;
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                imem_we  = 1'b1;
                busy     = 1'b1;
                state_nx = last_word ? DONE : RECV;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            imem_wd  <= '0;
            checksum <= '0;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_words  <= (load_words > DEPTH_W) ? DEPTH_W : load_words;
                        word_idx <= '0;
                        byte_idx <= '0;
                        checksum <= '0;
                        cpu_hold <= 1'b1;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        imem_wd[{byte_idx, 3'b000} +: 8] <= byte_in;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    checksum <= checksum + imem_wd;
                    // Index stops at the last word, so it never passes DEPTH-1.
                    if (!last_word) word_idx <= word_idx + 1'b1;
                end
                DONE: cpu_hold <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, gapped, empty, clamped and aborted loads.
`timescale 1ns/1ps
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset, start, byte_valid;
    logic [6:0]  load_words;
    logic [7:0]  byte_in;
    logic        byte_ready, imem_we, cpu_hold, busy, done;
    logic [31:0] imem_wa, imem_wd, checksum;

    int total = 0, bad = 0;
    int wr_n = 0, done_n = 0;
    logic [31:0] wa_log [256];
    logic [31:0] wd_log [256];

    imem_loader #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .load_words(load_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Write/done log sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_n < 256) begin
                wa_log[wr_n] = imem_wa;
                wd_log[wr_n] = imem_wd;
            end
            wr_n++;
        end
        if (done) done_n++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] n);
        start      = 1'b1;
        load_words = n;
        tick;
        start      = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pat [8];
        logic [7:0]  pat2 [4];
        logic [31:0] sum, w;
        int base, d0;
        pat  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
        pat2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        reset = 1'b1; start = 1'b0; load_words = '0; byte_in = '0; byte_valid = 1'b0;

        // 1: reset and idle
        tick; tick;
        reset = 1'b0;
        repeat (5) tick;
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);

        // 2: two words back-to-back
        base = wr_n; d0 = done_n;
        do_start(7'd2);
        chk("t2_hold_on_start", cpu_hold, 1);
        chk("t2_busy", busy, 1);
        for (int i = 0; i < 4; i++) send(pat[i]);
        chk("t2_we0", imem_we, 1);
        chk("t2_wa0", imem_wa, 32'h0);
        chk("t2_wd0", imem_wd, 32'h00000013);
        chk("t2_ready_in_write", byte_ready, 0);
        for (int i = 4; i < 8; i++) send(pat[i]);
        chk("t2_we1", imem_we, 1);
        chk("t2_wa1", imem_wa, 32'h4);
        chk("t2_wd1", imem_wd, 32'h005000B3);
        tick;
        chk("t2_done", done, 1);
        tick;
        chk("t2_done_1cyc", done, 0);
        chk("t2_hold_released", cpu_hold, 0);
        chk("t2_checksum", checksum, 32'h005000C6);
        chk("t2_writes", 32'(wr_n - base), 2);
        chk("t2_done_cnt", 32'(done_n - d0), 1);

        // 3: same load with 3-cycle gaps between bytes
        base = wr_n;
        do_start(7'd2);
        for (int i = 0; i < 8; i++) begin
            send(pat[i]);
            for (int g = 0; g < 3; g++) begin
                if (i % 4 == 3 && g == 0) begin
                    chk("t3_gap_we", imem_we, 1);
                    chk("t3_gap_ready_write", byte_ready, 0);
                end else if (i == 7) begin
                    if (g == 1) chk("t3_done", done, 1);
                end else begin
                    chk("t3_gap_ready", byte_ready, 1);
                end
                tick;
            end
        end
        chk("t3_writes", 32'(wr_n - base), 2);
        chk("t3_wa0", wa_log[base], 32'h0);
        chk("t3_wd0", wd_log[base], 32'h00000013);
        chk("t3_wa1", wa_log[base+1], 32'h4);
        chk("t3_wd1", wd_log[base+1], 32'h005000B3);
        chk("t3_checksum", checksum, 32'h005000C6);
        chk("t3_hold", cpu_hold, 0);

        // 4: zero-length load releases the CPU
        base = wr_n;
        do_start(7'd0);
        chk("t4_done", done, 1);
        chk("t4_hold_during_done", cpu_hold, 1);
        chk("t4_no_we", imem_we, 0);
        tick;
        chk("t4_hold_released", cpu_hold, 0);
        chk("t4_checksum", checksum, 0);
        chk("t4_writes", 32'(wr_n - base), 0);

        // 5: load_words=100 clamps to 64; a stray start mid-load is ignored
        base = wr_n; d0 = done_n;
        sum = '0;
        for (int k = 0; k < 64; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            sum = sum + w;
        end
        do_start(7'd100);
        for (int j = 0; j < 256; j++) begin
            if (j == 10) begin
                start = 1'b1;
                load_words = 7'd1;
            end
            send(8'(j));
            start = 1'b0;
        end
        tick; tick;
        chk("t5_writes", 32'(wr_n - base), 64);
        chk("t5_wa1", wa_log[base+1], 32'h4);
        chk("t5_last_wa", wa_log[base+63], 32'hFC);
        chk("t5_last_wd", wd_log[base+63], 32'hFFFEFDFC);
        chk("t5_done_cnt", 32'(done_n - d0), 1);
        chk("t5_checksum", checksum, sum);
        chk("t5_idle_ready", byte_ready, 0);

        // 6: reset mid-load aborts, then a fresh one-word load
        base = wr_n; d0 = done_n;
        do_start(7'd3);
        for (int i = 0; i < 6; i++) send(8'(i + 1));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_hold_after_rst", cpu_hold, 1);
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_ready_after_rst", byte_ready, 0);
        chk("t6_checksum_rst", checksum, 0);
        repeat (3) tick;
        chk("t6_no_done", 32'(done_n - d0), 0);
        chk("t6_partial_writes", 32'(wr_n - base), 1);
        do_start(7'd1);
        for (int i = 0; i < 4; i++) send(pat2[i]);
        chk("t6_we", imem_we, 1);
        chk("t6_wa", imem_wa, 32'h0);
        chk("t6_wd", imem_wd, 32'hDDCCBBAA);
        tick;
        chk("t6_done", done, 1);
        tick;
        chk("t6_checksum", checksum, 32'hDDCCBBAA);
        chk("t6_hold_released", cpu_hold, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
